hamming_serial_rx: RTL and testbench

Serial receiver that sits directly upstream of the Hamming(7,4) decode/correct stage. It deserializes UART-style frames, each carrying one 7-bit Hamming codeword. It presents the codeword on code_out with a one-cycle code_valid strobe, and that output drives the decoder's raw-codeword input (the input selected with selector=1). It does no Hamming decoding itself; it only captures and frames codewords.

---
 rtl/hamming_serial_rx.sv | 124 ++++++++++++
 tb/tb_hamming_serial_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_rx.sv
// UART-style deserializer for 7-bit Hamming codewords (start, 7 data LSB first, stop).
// Emits the captured codeword with a one-cycle code_valid, or a one-cycle frame_err on a bad stop bit.
module hamming_serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] code_out,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic          START_LEVEL = ~IDLE_LEVEL;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [6:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_s_q    <= IDLE_LEVEL;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_s_q == START_LEVEL) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        // Re-check at mid start bit so short glitches are rejected
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = (rx_s_q == START_LEVEL) ? S_DATA : S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[6:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd6) state_d = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s_q == IDLE_LEVEL) begin
            code_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q == IDLE_LEVEL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Scoreboard bench for hamming_serial_rx: two instances (16 and 4 clocks per bit),
// expected strobes queued by the stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_hamming_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1, rx4 = 1'b1;
  logic [6:0] co16, co4;
  logic       cv16, cv4, fe16, fe4, bz16, bz4;

  always #5 clk = ~clk;

  hamming_serial_rx #(.CLKS_PER_BIT(16), .IDLE_LEVEL(1'b1)) dut16 (
    .clk(clk), .rst(rst), .rx_in(rx16), .code_out(co16),
    .code_valid(cv16), .frame_err(fe16), .busy(bz16)
  );

  hamming_serial_rx #(.CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) dut4 (
    .clk(clk), .rst(rst), .rx_in(rx4), .code_out(co4),
    .code_valid(cv4), .frame_err(fe4), .busy(bz4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  // entry: bit7 = frame_err expected, [6:0] = code_out expected at the strobe
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [6:0] mcode[2];
  logic       prev_st[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic cv, input logic fe, input logic [6:0] co);
    logic [7:0] e;
    int sz;
    if (cv === 1'b1 || fe === 1'b1) begin
      check($sformatf("exclusive_dut%0d", d), 32'(cv & fe), 0);
      check($sformatf("no_consecutive_dut%0d", d), 32'(prev_st[d]), 0);
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe_dut%0d: got valid=%0b err=%0b required none (t=%0t)",
                 d, cv, fe, $time);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("strobe_kind_dut%0d", d), 32'(fe), 32'(e[7]));
        check($sformatf("code_out_dut%0d", d), 32'(co), 32'(e[6:0]));
      end
    end
    prev_st[d] = (cv === 1'b1) || (fe === 1'b1);
  endtask

  initial begin
    prev_st[0] = 1'b0;
    prev_st[1] = 1'b0;
  end

  always @(negedge clk) begin
    mon(0, cv16, fe16, co16);
    mon(1, cv4, fe4, co4);
  end

  task automatic set_line(input int d, input logic v);
    if (d == 0) rx16 = v;
    else        rx4  = v;
  endtask

  task automatic push_ok(input int d, input logic [6:0] w);
    if (d == 0) q0.push_back({1'b0, w});
    else        q1.push_back({1'b0, w});
    mcode[d] = w;
  endtask

  task automatic push_err(input int d);
    if (d == 0) q0.push_back({1'b1, mcode[d]});
    else        q1.push_back({1'b1, mcode[d]});
  endtask

  task automatic send_frame(input int d, input logic [6:0] w, input logic stop_lvl,
                            input realtime bt, input bit align);
    if (align) @(negedge clk);
    set_line(d, 1'b0);
    #(bt);
    for (int i = 0; i < 7; i++) begin
      set_line(d, w[i]);
      #(bt);
    end
    set_line(d, stop_lvl);
    #(bt);
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_dut%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    logic [6:0] w;
    realtime bt;
    mcode[0] = '0;
    mcode[1] = '0;

    // reset and idle line
    repeat (3) @(negedge clk);
    check("reset_outs_dut16", {co16, cv16, fe16, bz16}, 0);
    check("reset_outs_dut4", {co4, cv4, fe4, bz4}, 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outs_dut16", {co16, cv16, fe16, bz16}, 0);
    end
    check("idle_outs_dut4", {co4, cv4, fe4, bz4}, 0);

    // reset in the middle of the data bits
    @(negedge clk);
    rx16 = 1'b0;
    #(160.0);
    rx16 = 1'b1;
    #(320.0);
    @(negedge clk);
    check("busy_mid_data", 32'(bz16), 1);
    rst = 1'b1;
    @(negedge clk);
    check("busy_after_rst", 32'(bz16), 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("busy_after_abort", 32'(bz16), 0);

    // single frame
    push_ok(0, 7'b1010010);
    send_frame(0, 7'b1010010, 1'b1, 160.0, 1'b1);
    wait_drain(0);
    check("frame_err_low", 32'(fe16), 0);

    // back-to-back frames with no idle gap
    push_ok(0, 7'b1110001);
    push_ok(0, 7'b0000001);
    send_frame(0, 7'b1110001, 1'b1, 160.0, 1'b1);
    send_frame(0, 7'b0000001, 1'b1, 160.0, 1'b0);
    wait_drain(0);
    check("hold_code", 32'(co16), 32'(7'b0000001));

    // bad stop bit, line held low a further 3 bits
    push_err(0);
    send_frame(0, 7'b0110011, 1'b0, 160.0, 1'b1);
    #(240.0);
    check("busy_stuck_low", 32'(bz16), 1);
    #(240.0);
    rx16 = 1'b1;
    repeat (5) @(negedge clk);
    check("busy_after_release", 32'(bz16), 0);
    wait_drain(0);
    check("code_kept_after_err", 32'(co16), 32'(7'b0000001));

    // short glitch on idle line
    @(negedge clk);
    rx16 = 1'b0;
    repeat (4) @(negedge clk);
    rx16 = 1'b1;
    repeat (16) @(negedge clk);
    check("busy_after_glitch", 32'(bz16), 0);
    repeat (40) @(negedge clk);

    // random words at +/-3% bit-period skew on both instances
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 6; k++) begin
        w  = 7'($urandom_range(0, 127));
        bt = ((d == 0) ? 160.0 : 40.0) * (((k % 2) == 0) ? 0.97 : 1.03);
        push_ok(d, w);
        send_frame(d, w, 1'b1, bt, 1'b1);
        wait_drain(d);
        #(2.0 * bt);
      end
    end

    repeat (50) @(negedge clk);
    check("queue_empty_dut16", q0.size(), 0);
    check("queue_empty_dut4", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
